mem_slave: RTL and testbench

MEM_SLAVE -- requirements
Module: mem_slave

---
 rtl/mem_slave_pkg.sv | 18 +
 rtl/mem_slave_ram.sv | 32 +++
 rtl/mem_slave.sv | 175 +++++++++++++++++
 tb/tb_mem_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_slave_pkg.sv
// Shared encodings for the mem_slave burst memory: FSM states and write-response codes.
package mem_slave_pkg;

  typedef enum logic {
    StRIdle,
    StRData
  } r_state_e;

  typedef enum logic [1:0] {
    StWIdle,
    StWData,
    StWResp
  } w_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/mem_slave_ram.sv
// Byte-wide storage for mem_slave: one synchronous write port, one combinational read port,
// synchronous whole-array clear.
module mem_slave_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_slave.sv
// Burst memory slave with independent read and write channels sharing one storage array.
module mem_slave
  import mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [ID_W-1:0]   ARID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RRESP,
  output logic              RLAST,
  output logic [ID_W-1:0]   RID,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [ID_W-1:0]   AWID,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic [ID_W-1:0]   BID
);

  localparam int unsigned SumW = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] raddr_q;
  logic [LEN_W-1:0]  rlen_q, rcnt_q;
  logic [ID_W-1:0]   rid_q;
  logic              rerr_q;
  logic [DATA_W-1:0] rdata_q;

  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [LEN_W-1:0]  wlen_q, wcnt_q;
  logic [ID_W-1:0]   wid_q;
  logic              werr_q;
  logic [1:0]        bresp_q;

  logic              ar_fire, r_fire, aw_fire, w_fire, b_fire, w_end, w_at_len;
  logic [SumW-1:0]   ar_end, aw_end;
  logic              ar_ovf, aw_ovf;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign ar_fire  = ARVALID & ARREADY;
  assign r_fire   = RVALID & RREADY;
  assign aw_fire  = AWVALID & AWREADY;
  assign w_fire   = WVALID & WREADY;
  assign b_fire   = BVALID & BREADY;
  assign w_at_len = (wcnt_q == wlen_q);
  assign w_end    = WLAST | w_at_len;

  assign ar_end = SumW'(ARADDR) + SumW'(ARLEN);
  assign aw_end = SumW'(AWADDR) + SumW'(AWLEN);
  assign ar_ovf = (ar_end >> ADDR_W) != '0;
  assign aw_ovf = (aw_end >> ADDR_W) != '0;

  // Beat data is captured at the edge that starts or advances a beat, so it holds under
  // stall and a same-cycle write to that address is not seen until the next access.
  assign ram_raddr = (r_state_q == StRIdle) ? ARADDR : raddr_q + ADDR_W'(1);

  mem_slave_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .clr   (rst),
    .we    (w_fire),
    .waddr (waddr_q),
    .wdata (WDATA),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      StRIdle: if (ar_fire) r_state_d = StRData;
      StRData: if (r_fire && RLAST) r_state_d = StRIdle;
      default: r_state_d = StRIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= StRIdle;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rid_q     <= '0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_fire) begin
        raddr_q <= ARADDR;
        rlen_q  <= ARLEN;
        rcnt_q  <= '0;
        rid_q   <= ARID;
        rerr_q  <= ar_ovf;
        rdata_q <= ram_rdata;
      end else if (r_fire) begin
        raddr_q <= raddr_q + ADDR_W'(1);
        rcnt_q  <= rcnt_q + LEN_W'(1);
        if (!RLAST) rdata_q <= ram_rdata;
      end
    end
  end

  assign ARREADY = (r_state_q == StRIdle);
  assign RVALID  = (r_state_q == StRData);
  assign RLAST   = RVALID & (rcnt_q == rlen_q);
  assign RRESP   = RVALID & rerr_q;
  assign RDATA   = rdata_q;
  assign RID     = rid_q;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      StWIdle: if (aw_fire) w_state_d = StWData;
      StWData: if (w_fire && w_end) w_state_d = StWResp;
      StWResp: if (b_fire) w_state_d = StWIdle;
      default: w_state_d = StWIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= StWIdle;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wid_q     <= '0;
      werr_q    <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      if (aw_fire) begin
        waddr_q <= AWADDR;
        wlen_q  <= AWLEN;
        wcnt_q  <= '0;
        wid_q   <= AWID;
        werr_q  <= aw_ovf;
      end
      if (w_fire) begin
        waddr_q <= waddr_q + ADDR_W'(1);
        wcnt_q  <= wcnt_q + LEN_W'(1);
        // WLAST disagreeing with the announced length marks the burst as malformed.
        if (w_end) bresp_q <= (werr_q || (WLAST != w_at_len)) ? RespSlverr : RespOkay;
      end
    end
  end

  assign AWREADY = (w_state_q == StWIdle);
  assign WREADY  = (w_state_q == StWData);
  assign BVALID  = (w_state_q == StWResp);
  assign BRESP   = bresp_q;
  assign BID     = wid_q;

endmodule

// File: tb/tb_mem_slave.sv
// Directed and randomized bench for mem_slave against a flat byte-array reference model.
module tb_mem_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       ARVALID, ARREADY, RVALID, RREADY, RRESP, RLAST;
  logic [7:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [3:0] ARLEN, ARID, RID, AWLEN, AWID, BID;
  logic       AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [1:0] BRESP;

  int         total = 0;
  int         bad = 0;
  logic [7:0] model [256];
  logic [7:0] wbuf [16];

  always #5 clk = ~clk;

  mem_slave dut (
    .clk     (clk),
    .rst     (rst),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARID    (ARID),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RLAST   (RLAST),
    .RID     (RID),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .AWLEN   (AWLEN),
    .AWID    (AWID),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WLAST   (WLAST),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .BID     (BID)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // wl is the beat index carrying WLAST; a value above len means WLAST never asserts.
  task automatic do_write(input int addr, input int len, input int id, input int wl,
                          input bit bstall);
    int n, to;
    bit err;
    n   = ((wl < len) ? wl : len) + 1;
    err = (wl != len) || (addr + len > 255);
    AWVALID = 1'b1;
    AWADDR  = 8'(addr);
    AWLEN   = 4'(len);
    AWID    = 4'(id);
    to = 0;
    while (!AWREADY && to < 50) begin tick(); to++; end
    check("awready", 32'(AWREADY), 1);
    tick();
    AWVALID = 1'b0;
    for (int k = 0; k < n; k++) begin
      WVALID = 1'b1;
      WDATA  = wbuf[k];
      WLAST  = (k == wl);
      to = 0;
      while (!WREADY && to < 50) begin tick(); to++; end
      check("wready", 32'(WREADY), 1);
      tick();
      model[(addr + k) % 256] = wbuf[k];
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    check("w_burst_end", 32'(WREADY), 0);
    if (bstall) begin
      BREADY = 1'b0;
      for (int s = 0; s < 2; s++) begin
        check("bvalid_hold", 32'(BVALID), 1);
        check("bresp_hold", 32'(BRESP), err ? 32'd2 : 32'd0);
        tick();
      end
    end
    check("bvalid", 32'(BVALID), 1);
    check("bresp", 32'(BRESP), err ? 32'd2 : 32'd0);
    check("bid", 32'(BID), 32'(id));
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_clr", 32'(BVALID), 0);
    check("awready_back", 32'(AWREADY), 1);
  endtask

  task automatic do_read(input int addr, input int len, input int id, input logic [15:0] pat,
                         input bit use_pat);
    int beat, cyc, to;
    bit rdy, err;
    err = (addr + len > 255);
    ARVALID = 1'b1;
    ARADDR  = 8'(addr);
    ARLEN   = 4'(len);
    ARID    = 4'(id);
    to = 0;
    while (!ARREADY && to < 50) begin tick(); to++; end
    check("arready", 32'(ARREADY), 1);
    tick();
    ARVALID = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 200) begin
      rdy = use_pat ? pat[cyc % 16] : ($urandom_range(0, 3) != 0);
      RREADY = rdy;
      check("rvalid", 32'(RVALID), 1);
      check("rdata", 32'(RDATA), 32'(model[(addr + beat) % 256]));
      check("rlast", 32'(RLAST), 32'(beat == len));
      check("rresp", 32'(RRESP), 32'(err));
      check("rid", 32'(RID), 32'(id));
      if (RVALID && rdy) beat++;
      tick();
      cyc++;
    end
    RREADY = 1'b0;
    check("rbeats", 32'(beat), 32'(len + 1));
    check("rvalid_clr", 32'(RVALID), 0);
    check("arready_back", 32'(ARREADY), 1);
  endtask

  initial begin
    int a, l, wl;
    ARVALID = 0; ARADDR = 0; ARLEN = 0; ARID = 0; RREADY = 0;
    AWVALID = 0; AWADDR = 0; AWLEN = 0; AWID = 0;
    WVALID = 0; WDATA = 0; WLAST = 0; BREADY = 0;
    do_reset();

    check("rst_arready", 32'(ARREADY), 1);
    check("rst_awready", 32'(AWREADY), 1);
    check("rst_rvalid", 32'(RVALID), 0);
    check("rst_rlast", 32'(RLAST), 0);
    check("rst_rresp", 32'(RRESP), 0);
    check("rst_wready", 32'(WREADY), 0);
    check("rst_bvalid", 32'(BVALID), 0);
    check("rst_rdata", 32'(RDATA), 0);
    check("rst_rid", 32'(RID), 0);
    check("rst_bresp", 32'(BRESP), 0);
    check("rst_bid", 32'(BID), 0);

    // Basic 4-beat write then read back.
    for (int k = 0; k < 4; k++) wbuf[k] = 8'hA0 + 8'(k);
    do_write(8'h10, 3, 5, 3, 1'b0);
    do_read(8'h10, 3, 5, 16'hFFFF, 1'b1);

    // Wrap past the top of memory: write and read both flag an error.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(8'hFE, 2, 3, 2, 1'b1);
    do_read(8'hFE, 2, 9, 16'hFFFF, 1'b1);

    // Early WLAST and missing WLAST both terminate the burst with SLVERR.
    wbuf[0] = 8'h5A; wbuf[1] = 8'h5B; wbuf[2] = 8'h5C; wbuf[3] = 8'h5D;
    do_write(8'h30, 3, 1, 1, 1'b0);
    do_write(8'h38, 1, 2, 15, 1'b0);
    do_read(8'h30, 3, 4, 16'hFFFF, 1'b1);

    // RREADY pattern 1,0,0,1,1 over a 3-beat burst.
    do_read(8'h10, 2, 6, 16'b0000_0000_0001_1001, 1'b1);

    // Same-cycle write and read of 8'h20: read sees the old byte.
    AWVALID = 1'b1; AWADDR = 8'h20; AWLEN = 4'd0; AWID = 4'd7;
    tick();
    AWVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 8'h20; ARLEN = 4'd0; ARID = 4'd8;
    WVALID = 1'b1; WDATA = 8'h55; WLAST = 1'b1;
    check("conc_arready", 32'(ARREADY), 1);
    check("conc_wready", 32'(WREADY), 1);
    tick();
    ARVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    check("conc_rdata_old", 32'(RDATA), 32'h00);
    check("conc_bvalid", 32'(BVALID), 1);
    RREADY = 1'b1; BREADY = 1'b1;
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    model[8'h20] = 8'h55;
    do_read(8'h20, 0, 8, 16'hFFFF, 1'b1);

    // Randomized traffic against the model.
    for (int t = 0; t < 24; t++) begin
      a = $urandom_range(0, 255);
      l = $urandom_range(0, 15);
      wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : l;
      for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
      do_write(a, l, $urandom_range(0, 15), wl, 1'($urandom_range(0, 1)));
      do_read((a + $urandom_range(0, 3)) % 256, $urandom_range(0, 15), $urandom_range(0, 15),
              16'h0, 1'b0);
    end

    // Reset in the middle of concurrent 4-beat read and write bursts.
    for (int k = 0; k < 4; k++) wbuf[k] = 8'hC0 + 8'(k);
    do_write(8'h40, 3, 1, 3, 1'b0);
    ARVALID = 1'b1; ARADDR = 8'h40; ARLEN = 4'd3; ARID = 4'd2;
    AWVALID = 1'b1; AWADDR = 8'h60; AWLEN = 4'd3; AWID = 4'd3;
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0;
    RREADY = 1'b1; WVALID = 1'b1; WDATA = 8'hE0;
    tick();
    WDATA = 8'hE1;
    rst = 1'b1;
    tick();
    rst = 1'b0; RREADY = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    check("mid_rvalid", 32'(RVALID), 0);
    check("mid_bvalid", 32'(BVALID), 0);
    check("mid_arready", 32'(ARREADY), 1);
    check("mid_awready", 32'(AWREADY), 1);
    check("mid_wready", 32'(WREADY), 0);
    tick();
    check("mid_bvalid_late", 32'(BVALID), 0);
    check("mid_rvalid_late", 32'(RVALID), 0);
    do_read(8'h40, 3, 0, 16'hFFFF, 1'b1);
    do_read(8'h60, 3, 0, 16'hFFFF, 1'b1);
    do_read(8'h10, 3, 0, 16'hFFFF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
